load_store_unit: RTL and testbench
==================================

# load_store_unit

Multicycle load/store engine between the datapath's ALUOut/B registers and the 64-bit data memory (Memoria64). It accepts one memory request at a time and handles RV64 widths: lb/lh/lw/ld/lbu/lhu/lwu and sb/sh/sw/sd. Loads are sign- or zero-extended into a 64-bit result for the write-data mux. Sub-doubleword stores are done as read-modify-write, so the memory only ever sees full, aligned doubleword accesses.

## Interface
Parameters:
- MEM_LAT, 1 — cycles from mem_raddr presented to mem_rdata valid (≥1)

Ports:
- clk  in  1  clock; everything on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request strobe; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load; sampled with start
- funct3  in  3  width/sign code; sampled with start
- addr  in  64  byte address; sampled with start
- store_data  in  64  store source, low bytes used; sampled with start
- busy  out  1  high from cycle after accepted start through the done cycle
- done  out  1  one-cycle completion pulse
- load_data  out  64  extended load result; held until next completed load
- misaligned  out  1  valid with done; 1 = request rejected
- mem_raddr  out  64  doubleword-aligned read address
- mem_waddr  out  64  doubleword-aligned write address
- mem_wdata  out  64  full doubleword to write
- mem_wr  out  1  memory write enable, one cycle
- mem_rdata  in  64  memory read data

## Operation
- Clock is clk; reset is synchronous, active-high.
- FSM states: IDLE, REQ, WAIT, WRITE, DONE.
- Accepting a request: start in IDLE latches addr, funct3, is_store and store_data. addr[2:0] becomes the offset; the aligned base is addr with bits [2:0] cleared.
- start outside IDLE is ignored; it is neither queued nor an error.
- Loads by funct3:
  - 000 lb, 001 lh, 010 lw, 011 ld: sign-extend.
  - 100 lbu, 101 lhu, 110 lwu: zero-extend.
  - 111: treated as misaligned.
- Stores by funct3: 000 sb, 001 sh, 010 sw, 011 sd. Codes 1xx are treated as misaligned.
- Byte lanes are little-endian: offset k maps to bits [8k+7:8k].
- Alignment rule: the offset must be a multiple of the access size. Violation goes IDLE→DONE with misaligned=1. There is no memory read or write, and load_data is unchanged.
- Load path: IDLE→REQ (mem_raddr=base) → WAIT (MEM_LAT−1 further cycles, may be zero) → capture the lane, extend, register into load_data → DONE.
- sd path: IDLE→WRITE (mem_waddr=base, mem_wdata=store_data, mem_wr=1) → DONE. There is no read.
- sb/sh/sw path: REQ → WAIT → WRITE. In WRITE, mem_wdata is the captured doubleword with the addressed lanes replaced by the low bytes of store_data → DONE.
- mem_wr is high only in WRITE.
- mem_raddr and mem_waddr are base in every state except IDLE, where they are 0.
- DONE lasts one cycle with done=1, then returns to IDLE. A start in that DONE cycle is ignored.
- Reset values: state IDLE; busy, done, misaligned, mem_wr = 0; load_data, mem_raddr, mem_waddr, mem_wdata = 0.
- Reset mid-operation aborts the request. No write is issued after the reset edge.

## Timing
- Cycle 0 is the cycle in which start is high in IDLE.
- Completion cycle (done high):
  - load: cycle MEM_LAT+2
  - sd: cycle 2
  - sb/sh/sw: cycle MEM_LAT+3
  - misaligned: cycle 1
- Store write cycle (mem_wr high): sd cycle 1; sb/sh/sw cycle MEM_LAT+2.
- load_data updates on the edge entering DONE. It is stable throughout the done cycle.
- busy is high from cycle 1 up to and including the done cycle.
- Next accepted start is the cycle after done at the earliest.

## Structure
- lsu_pkg holds:
  - the state enum;
  - funct3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - a size-from-funct3 function.
- Sub-module lsu_lane_align (combinational) does lane extract plus sign/zero extension, and lane merge for stores. The top holds the FSM, the request latches and the MEM_LAT counter.

## Test plan
- ld at 0x10, memory dword 0x0123456789ABCDEF, MEM_LAT=1 → done in cycle 3, load_data=0x0123456789ABCDEF, mem_wr never high.
- lb at 0x13 where byte 3 is 0x80 → load_data=0xFFFFFFFFFFFFFF80. lbu at the same address → 0x0000000000000080.
- sh at 0x0A, data 0xBEEF, dword at 0x08 = 0x1122334455667788 → single mem_wr in cycle 3 with mem_waddr=0x08, mem_wdata=0x11223344BEEF7788; done in cycle 4.
- lw at 0x06 → done and misaligned in cycle 1, no mem_wr, load_data unchanged. Repeat with sd at 0x04, same result.
- sd 0xDEADBEEF00000001 at 0x20 → mem_wr in cycle 1, done in cycle 2. A start pulse in cycle 1 is ignored: no second done.
- Reset asserted in WAIT of an sb → next cycle IDLE, all outputs 0, mem_wr never asserted. Repeat the loads with MEM_LAT=3 to confirm done in cycle 5.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV64
// load/store width codes and the access size lookup.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Access size in bytes; the unsigned variants share the low two bits.
  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane handling: extract and extend a load lane from a
// doubleword, and merge store bytes into a doubleword for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [63:0] store_data,
  output logic [63:0] load_ext,
  output logic [63:0] merged
);

  logic [5:0]         shamt;
  logic [63:0]        lane;
  logic [63:0]        mask;
  logic signed [7:0]  b_s;
  logic signed [15:0] h_s;
  logic signed [31:0] w_s;

  assign shamt = {offset, 3'b000};

  always_comb begin
    lane = rdata >> shamt;
    b_s  = lane[7:0];
    h_s  = lane[15:0];
    w_s  = lane[31:0];
    case (funct3)
      F3_B:    load_ext = 64'(b_s);
      F3_H:    load_ext = 64'(h_s);
      F3_W:    load_ext = 64'(w_s);
      F3_BU:   load_ext = {56'd0, lane[7:0]};
      F3_HU:   load_ext = {48'd0, lane[15:0]};
      F3_WU:   load_ext = {32'd0, lane[31:0]};
      default: load_ext = lane;
    endcase

    case (funct3[1:0])
      2'b00:   mask = 64'h0000_0000_0000_00FF;
      2'b01:   mask = 64'h0000_0000_0000_FFFF;
      2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    mask   = mask << shamt;
    merged = (rdata & ~mask) | ((store_data << shamt) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle RV64 load/store engine; sub-doubleword stores are done as
// read-modify-write so memory only sees aligned doubleword accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [63:0] load_data,
  output logic        misaligned,
  output logic [63:0] mem_raddr,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  input  logic [63:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t             state;
  logic               is_store_q;
  logic [2:0]         f3_q;
  logic [2:0]         off_q;
  logic [63:0]        sdata_q;
  logic [CNT_W-1:0]   cnt;

  logic [63:0]        base_in;
  logic [3:0]         size_in;
  logic               mis_in;
  logic [63:0]        load_ext;
  logic [63:0]        merged;

  always_comb begin
    base_in = {addr[63:3], 3'b000};
    size_in = size_bytes(funct3);
    mis_in  = (is_store && funct3[2]) ||
              (!is_store && funct3 == 3'b111) ||
              ((addr[2:0] & 3'(size_in - 4'd1)) != 3'd0);
  end

  lsu_lane_align u_align (
    .rdata      (mem_rdata),
    .offset     (off_q),
    .funct3     (f3_q),
    .store_data (sdata_q),
    .load_ext   (load_ext),
    .merged     (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      mem_wr     <= 1'b0;
      load_data  <= '0;
      mem_raddr  <= '0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      is_store_q <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      sdata_q    <= '0;
      cnt        <= '0;
    end else begin
      done   <= 1'b0;
      mem_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_store_q <= is_store;
            f3_q       <= funct3;
            off_q      <= addr[2:0];
            sdata_q    <= store_data;
            busy       <= 1'b1;
            mem_raddr  <= base_in;
            mem_waddr  <= base_in;
            misaligned <= mis_in;
            if (mis_in) begin
              done  <= 1'b1;
              state <= DONE;
            end else if (is_store && funct3 == F3_D) begin
              // Full doubleword store needs no read.
              mem_wdata <= store_data;
              mem_wr    <= 1'b1;
              state     <= WRITE;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          cnt   <= CNT_W'(MEM_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          // mem_rdata is valid in the last WAIT cycle.
          if (cnt == '0) begin
            if (is_store_q) begin
              mem_wdata <= merged;
              mem_wr    <= 1'b1;
              state     <= WRITE;
            end else begin
              load_data <= load_ext;
              done      <= 1'b1;
              state     <= DONE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WRITE: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy      <= 1'b0;
          mem_raddr <= '0;
          mem_waddr <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench: two units (MEM_LAT=1 and MEM_LAT=3) run the same
// request stream against their own doubleword memory models.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset, start, is_store;
  logic [2:0]  funct3;
  logic [63:0] addr, store_data;

  logic        busy1, done1, mis1, wr1;
  logic [63:0] ld1, ra1, wa1, wd1, rdata1;
  logic        busy3, done3, mis3, wr3;
  logic [63:0] ld3, ra3, wa3, wd3, rdata3, d3a, d3b;

  logic [63:0] mem1 [0:15];
  logic [63:0] mem3 [0:15];
  bit          mem_init;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy1), .done(done1), .load_data(ld1),
    .misaligned(mis1), .mem_raddr(ra1), .mem_waddr(wa1), .mem_wdata(wd1),
    .mem_wr(wr1), .mem_rdata(rdata1)
  );

  load_store_unit #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy3), .done(done3), .load_data(ld3),
    .misaligned(mis3), .mem_raddr(ra3), .mem_waddr(wa3), .mem_wdata(wd3),
    .mem_wr(wr3), .mem_rdata(rdata3)
  );

  // Memory models: read data appears MEM_LAT cycles after the address.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) begin
        mem1[i] <= 64'd0;
        mem3[i] <= 64'd0;
      end
      mem1[1] <= 64'h1122334455667788;
      mem3[1] <= 64'h1122334455667788;
      mem1[2] <= 64'h0123456789ABCDEF;
      mem3[2] <= 64'h0123456789ABCDEF;
    end else begin
      if (wr1) mem1[wa1[6:3]] <= wd1;
      if (wr3) mem3[wa3[6:3]] <= wd3;
    end
    rdata1 <= mem1[ra1[6:3]];
    d3a    <= mem3[ra3[6:3]];
    d3b    <= d3a;
    rdata3 <= d3b;
  end

  typedef struct {
    int          done_cyc;
    int          wr_cyc;
    logic        mis;
    logic [63:0] ld;
    logic [63:0] base;
    logic [63:0] wd;
  } exp_t;

  exp_t        q1[$];
  exp_t        q3[$];
  bit          fin [2];
  int          nwr [2];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_ld;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string p, input logic b, dn, ms, wr,
                          input logic [63:0] ld, ra, wa, wd);
    chk({p, "_busy0"}, 64'(b), 64'd0);
    chk({p, "_done0"}, 64'(dn), 64'd0);
    chk({p, "_mis0"}, 64'(ms), 64'd0);
    chk({p, "_wr0"}, 64'(wr), 64'd0);
    chk({p, "_ld0"}, ld, 64'd0);
    chk({p, "_raddr0"}, ra, 64'd0);
    chk({p, "_waddr0"}, wa, 64'd0);
    chk({p, "_wdata0"}, wd, 64'd0);
  endtask

  task automatic mon(input int w, input int cyc, input logic b, dn, ms, wr,
                     input logic [63:0] ld, ra, wa, wd);
    exp_t  e;
    int    qs;
    string p;
    p  = (w == 0) ? "lat1" : "lat3";
    qs = (w == 0) ? q1.size() : q3.size();
    if (!fin[w]) begin
      chk($sformatf("%s_busy_c%0d", p, cyc), 64'(b), 64'd1);
    end else begin
      chk($sformatf("%s_busy_after_c%0d", p, cyc), 64'(b), 64'd0);
      chk($sformatf("%s_extra_done_c%0d", p, cyc), 64'(dn), 64'd0);
    end
    if (wr) begin
      nwr[w]++;
      chk({p, "_wr_pending"}, 64'(qs != 0), 64'd1);
      if (qs != 0) begin
        e = (w == 0) ? q1[0] : q3[0];
        chk({p, "_wr_cycle"}, 64'(cyc), 64'(e.wr_cyc));
        chk({p, "_waddr"}, wa, e.base);
        chk({p, "_wdata"}, wd, e.wd);
      end
    end
    if (dn && !fin[w]) begin
      chk({p, "_done_pending"}, 64'(qs != 0), 64'd1);
      if (qs != 0) begin
        e = (w == 0) ? q1.pop_front() : q3.pop_front();
        chk({p, "_done_cycle"}, 64'(cyc), 64'(e.done_cyc));
        chk({p, "_misaligned"}, 64'(ms), 64'(e.mis));
        chk({p, "_load_data"}, ld, e.ld);
        chk({p, "_raddr"}, ra, e.base);
      end
      fin[w] = 1'b1;
    end
  endtask

  // Issues one request at a negedge and watches both units for 10 cycles.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [63:0] a, d,
                         input logic mis, input logic [63:0] ld_new, wd_exp, input int poke);
    exp_t e;
    int   lat;
    if (!st && !mis) exp_ld = ld_new;
    for (int w = 0; w < 2; w++) begin
      lat        = (w == 0) ? 1 : 3;
      e.mis      = mis;
      e.ld       = exp_ld;
      e.base     = {a[63:3], 3'b000};
      e.wd       = wd_exp;
      e.done_cyc = mis ? 1 : (st && f3 == 3'b011) ? 2 : st ? lat + 3 : lat + 2;
      e.wr_cyc   = (!st || mis) ? -1 : (f3 == 3'b011) ? 1 : lat + 2;
      if (w == 0) q1.push_back(e);
      else        q3.push_back(e);
      fin[w] = 1'b0;
      nwr[w] = 0;
    end
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = (cyc == poke);
      mon(0, cyc, busy1, done1, mis1, wr1, ld1, ra1, wa1, wd1);
      mon(1, cyc, busy3, done3, mis3, wr3, ld3, ra3, wa3, wd3);
    end
    chk("lat1_finished", 64'(fin[0]), 64'd1);
    chk("lat3_finished", 64'(fin[1]), 64'd1);
    chk("lat1_write_count", 64'(nwr[0]), (st && !mis) ? 64'd1 : 64'd0);
    chk("lat3_write_count", 64'(nwr[1]), (st && !mis) ? 64'd1 : 64'd0);
    q1.delete();
    q3.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 64'd0; store_data = 64'd0; mem_init = 1'b1; exp_ld = 64'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0; mem_init = 1'b0;
    chk_idle("rst_lat1", busy1, done1, mis1, wr1, ld1, ra1, wa1, wd1);
    chk_idle("rst_lat3", busy3, done3, mis3, wr3, ld3, ra3, wa3, wd3);

    run_req(1'b0, 3'b011, 64'h10, 64'd0, 1'b0, 64'h0123456789ABCDEF, 64'd0, 0);
    run_req(1'b1, 3'b000, 64'h13, 64'h80, 1'b0, 64'd0, 64'h0123456780ABCDEF, 0);
    run_req(1'b0, 3'b000, 64'h13, 64'd0, 1'b0, 64'hFFFFFFFFFFFFFF80, 64'd0, 0);
    run_req(1'b0, 3'b100, 64'h13, 64'd0, 1'b0, 64'h0000000000000080, 64'd0, 0);
    run_req(1'b0, 3'b001, 64'h12, 64'd0, 1'b0, 64'hFFFFFFFFFFFF80AB, 64'd0, 0);
    run_req(1'b0, 3'b110, 64'h14, 64'd0, 1'b0, 64'h0000000001234567, 64'd0, 0);
    run_req(1'b0, 3'b010, 64'h10, 64'd0, 1'b0, 64'hFFFFFFFF80ABCDEF, 64'd0, 0);
    run_req(1'b1, 3'b001, 64'h0A, 64'hBEEF, 1'b0, 64'd0, 64'h11223344BEEF7788, 0);
    run_req(1'b0, 3'b001, 64'h0A, 64'd0, 1'b0, 64'hFFFFFFFFFFFFBEEF, 64'd0, 0);
    run_req(1'b0, 3'b101, 64'h0A, 64'd0, 1'b0, 64'h000000000000BEEF, 64'd0, 0);
    // Misaligned and illegal codes: rejected without touching memory.
    run_req(1'b0, 3'b010, 64'h06, 64'd0, 1'b1, 64'd0, 64'd0, 0);
    run_req(1'b1, 3'b011, 64'h04, 64'h1234, 1'b1, 64'd0, 64'd0, 0);
    run_req(1'b0, 3'b111, 64'h10, 64'd0, 1'b1, 64'd0, 64'd0, 0);
    run_req(1'b1, 3'b100, 64'h20, 64'h99, 1'b1, 64'd0, 64'd0, 0);
    run_req(1'b1, 3'b011, 64'h20, 64'hDEADBEEF00000001, 1'b0, 64'd0, 64'hDEADBEEF00000001, 1);
    run_req(1'b1, 3'b010, 64'h24, 64'h12345678CAFEF00D, 1'b0, 64'd0, 64'hCAFEF00D00000001, 0);
    run_req(1'b0, 3'b011, 64'h20, 64'd0, 1'b0, 64'hCAFEF00D00000001, 64'd0, 0);

    // Reset during the WAIT phase of an sb aborts it with no write.
    start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 64'h08; store_data = 64'h55;
    @(negedge clk);
    start = 1'b0;
    chk("abort_c1_wr_lat1", 64'(wr1), 64'd0);
    chk("abort_c1_wr_lat3", 64'(wr3), 64'd0);
    @(negedge clk);
    chk("abort_c2_busy_lat1", 64'(busy1), 64'd1);
    chk("abort_c2_busy_lat3", 64'(busy3), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("abort_lat1", busy1, done1, mis1, wr1, ld1, ra1, wa1, wd1);
    chk_idle("abort_lat3", busy3, done3, mis3, wr3, ld3, ra3, wa3, wd3);
    exp_ld = 64'd0;
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("abort_c%0d_wr_lat1", c), 64'(wr1), 64'd0);
      chk($sformatf("abort_c%0d_wr_lat3", c), 64'(wr3), 64'd0);
      chk($sformatf("abort_c%0d_done_lat3", c), 64'(done3), 64'd0);
    end
    run_req(1'b0, 3'b011, 64'h08, 64'd0, 1'b0, 64'h11223344BEEF7788, 64'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
